ppu_pixel_fifo: RTL

PPU_PIXEL_FIFO -- requirements
Module: ppu_pixel_fifo

---
 rtl/ppu_pixel_fifo_if.sv | 37 +++
 rtl/ppu_pixel_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ppu_pixel_fifo_if.sv
// Pixel FIFO port bundle: BG row push, sprite row push and pixel output.
//
// Handshake rules: a push (bg_push / sp_push) is accepted in the cycle it is
// high only when its ready (bg_ready / sp_ready) is high in that same cycle.
// A push offered while ready is low is dropped and raises the sticky error
// flag. There is no back-pressure on the pixel side other than px_stall.
// Each px_valid pulse carries one pixel on px_out, one cycle after the pop
// that produced it.
interface ppu_pixel_fifo_if #(
    parameter int PW = 1
);
    logic          bg_push;
    logic [7:0]    bg_lo;
    logic [7:0]    bg_hi;
    logic          bg_ready;
    logic          sp_push;
    logic [7:0]    sp_lo;
    logic [7:0]    sp_hi;
    logic [PW-1:0] sp_pal;
    logic          sp_prio;
    logic          sp_ready;
    logic          px_stall;
    logic [1:0]    px_out;
    logic          px_valid;

    // Fetcher / display side
    modport master (
        output bg_push, bg_lo, bg_hi, sp_push, sp_lo, sp_hi, sp_pal, sp_prio, px_stall,
        input  bg_ready, sp_ready, px_out, px_valid
    );

    // Pixel FIFO side
    modport slave (
        input  bg_push, bg_lo, bg_hi, sp_push, sp_lo, sp_hi, sp_pal, sp_prio, px_stall,
        output bg_ready, sp_ready, px_out, px_valid
    );
endinterface

// File: rtl/ppu_pixel_fifo.sv
// PPU pixel FIFO: position-aligned BG and sprite FIFOs, fine-scroll discard,
// layer mixing through palettes, and per-line pixel sequencing.
module ppu_pixel_fifo #(
    parameter int DEPTH    = 16,
    parameter int OBJ_PALS = 2,
    parameter int LINE_W   = 160,
    localparam int PW = (OBJ_PALS > 1) ? $clog2(OBJ_PALS) : 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_start,
    input  logic [2:0]            discard,
    input  logic [7:0]            bgp,
    input  logic [8*OBJ_PALS-1:0] obp,
    input  logic                  bg_en,
    input  logic                  sp_en,
    ppu_pixel_fifo_if.slave       pix,
    output logic [CW-1:0]         bg_count,
    output logic                  line_done,
    output logic                  ovf,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISCARD = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]    idx;
        logic [PW-1:0] pal;
        logic          prio;
    } sp_ent_t;

    state_t     state, state_nxt;
    logic [1:0] bg_mem [DEPTH];
    sp_ent_t    sp_mem [DEPTH];
    logic [1:0] bg_nxt [DEPTH];
    sp_ent_t    sp_nxt [DEPTH];
    logic [CW-1:0] cnt_nxt;
    logic [AW-1:0] wr_base;
    logic [2:0] disc_cnt;
    logic [8:0] pix_cnt;

    logic bg_ok, sp_ok, pop, run_pop, bg_acc, sp_acc, err;
    logic [1:0] bi, si, shade;

    assign pix.bg_ready = bg_ok;
    assign pix.sp_ready = sp_ok;
    assign line_done    = (state == S_DONE);
    assign fsm_state    = state;

    // Acceptance and pop qualification from the pre-cycle occupancy
    always_comb begin
        bg_ok   = (bg_count <= CW'(DEPTH - 8));
        sp_ok   = (bg_count >= CW'(8));
        pop     = ((state == S_DISCARD) || (state == S_RUN)) && (bg_count != '0) &&
                  !pix.px_stall && !pix.sp_push && !line_start;
        run_pop = pop && (state == S_RUN);
        bg_acc  = pix.bg_push && bg_ok && !line_start;
        sp_acc  = pix.sp_push && sp_ok && !line_start;
        err     = !line_start && ((pix.bg_push && !bg_ok) || (pix.sp_push && !sp_ok));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: line_start restarts from anywhere; DONE and IDLE wait for it
    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = (discard != 3'd0) ? S_DISCARD : S_RUN;
        end else begin
            case (state)
                S_DISCARD: if (pop && disc_cnt == 3'd1) state_nxt = S_RUN;
                S_RUN:     if (run_pop && pix_cnt == 9'(LINE_W - 1)) state_nxt = S_DONE;
                default:   state_nxt = state;
            endcase
        end
    end

    // FIFO next contents: sprite merge at the head, shift on pop, then append
    always_comb begin
        bg_nxt  = bg_mem;
        sp_nxt  = sp_mem;
        cnt_nxt = bg_count;
        wr_base = AW'(bg_count - CW'(pop));
        if (line_start) begin
            for (int i = 0; i < DEPTH; i++) begin
                bg_nxt[i] = 2'd0;
                sp_nxt[i] = '0;
            end
            cnt_nxt = '0;
        end else begin
            if (sp_acc) begin
                for (int i = 0; i < 8; i++) begin
                    if (sp_mem[i].idx == 2'd0 &&
                        {pix.sp_hi[3'(7 - i)], pix.sp_lo[3'(7 - i)]} != 2'd0) begin
                        sp_nxt[i].idx  = {pix.sp_hi[3'(7 - i)], pix.sp_lo[3'(7 - i)]};
                        sp_nxt[i].pal  = pix.sp_pal;
                        sp_nxt[i].prio = pix.sp_prio;
                    end
                end
            end
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    bg_nxt[i] = bg_nxt[i + 1];
                    sp_nxt[i] = sp_nxt[i + 1];
                end
                bg_nxt[DEPTH - 1] = 2'd0;
                sp_nxt[DEPTH - 1] = '0;
            end
            if (bg_acc) begin
                for (int i = 0; i < 8; i++) begin
                    bg_nxt[wr_base + AW'(i)] = {pix.bg_hi[3'(7 - i)], pix.bg_lo[3'(7 - i)]};
                    sp_nxt[wr_base + AW'(i)] = '0;
                end
            end
            cnt_nxt = bg_count + (bg_acc ? CW'(8) : CW'(0)) - CW'(pop);
        end
    end

    // Mix the head pixel of both layers into a shade
    always_comb begin
        bi = bg_en ? bg_mem[0] : 2'd0;
        si = sp_en ? sp_mem[0].idx : 2'd0;
        if (si != 2'd0 && !(sp_mem[0].prio && bi != 2'd0))
            shade = obp[{sp_mem[0].pal, si, 1'b0} +: 2];
        else
            shade = bgp[{bi, 1'b0} +: 2];
    end

    // FIFO storage, counters, registered pixel output and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bg_mem[i] <= 2'd0;
                sp_mem[i] <= '0;
            end
            bg_count <= '0;
            disc_cnt <= 3'd0;
            pix_cnt  <= 9'd0;
            pix.px_out   <= 2'd0;
            pix.px_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            bg_mem   <= bg_nxt;
            sp_mem   <= sp_nxt;
            bg_count <= cnt_nxt;
            pix.px_valid <= run_pop;
            if (run_pop) pix.px_out <= shade;
            if (err) ovf <= 1'b1;
            if (line_start)
                disc_cnt <= discard;
            else if (pop && state == S_DISCARD)
                disc_cnt <= disc_cnt - 3'd1;
            if (line_start)
                pix_cnt <= 9'd0;
            else if (run_pop)
                pix_cnt <= pix_cnt + 9'd1;
        end
    end

endmodule
